clk_tick_gen: RTL and testbench

Consumer-side companion to the free-running `clk_div` counter. It takes the 32-bit counter bus and turns selected bits into single-cycle, same-domain enable strobes. This replaces the practice of clocking logic directly from divided bits. It also runs a programmable frame scheduler, which emits the game-logic `frame_tick` and a frame count. It sits between the counter and all rate-dependent logic: display scan, sprite animation, and game-state update.

---
 rtl/clk_tick_gen_pkg.sv | 24 ++
 rtl/clk_tick_gen_edge_strobe.sv | 28 ++
 rtl/clk_tick_gen.sv | 78 +++++++
 tb/tb_clk_tick_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_tick_gen_pkg.sv
// Shared definitions for the tick generator: scheduler state encodings,
// default counter-bit selects and a bit-pick helper used by the channels.
package clk_tick_gen_pkg;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int CNT_W    = 8;
   localparam int FCNT_W   = 16;
   localparam int SEL_W    = 5;
   localparam int DIV_W    = 32;

   // Channel 0 watches bit 2, channel 3 watches bit 24.
   localparam logic [19:0] SEL_DEFAULT = {5'd24, 5'd20, 5'd16, 5'd2};

   function automatic logic sel_bit(input logic [DIV_W-1:0] v,
                                    input logic [SEL_W-1:0] idx);
      return v[idx];
   endfunction

endpackage

// File: rtl/clk_tick_gen_edge_strobe.sv
// One strobe channel: registered rising-edge detector on a single counter bit,
// with a combinational rise output for same-cycle consumers.
module edge_strobe (
   input  logic clk,
   input  logic rst_n,
   input  logic en_prime,
   input  logic bit_in,
   output logic stb,
   output logic rise
);

   logic prev;

   // While priming, prev still captures the bit so a bit already high at
   // reset release is never mistaken for an edge.
   assign rise = bit_in & ~prev & ~en_prime;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= 1'b0;
         stb  <= 1'b0;
      end else begin
         prev <= bit_in;
         stb  <= rise;
      end
   end

endmodule

// File: rtl/clk_tick_gen.sv
// Turns selected clk_div bits into single-cycle enable strobes and schedules
// frame_tick every `period` frame-channel strobes, with pause and frame count.
module clk_tick_gen
   import clk_tick_gen_pkg::*;
#(
   parameter int                  NCH      = 4,
   parameter logic [5*NCH-1:0]    SEL      = SEL_DEFAULT,
   parameter int                  FRAME_CH = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [CNT_W-1:0]  period,
   input  logic              pause,
   output logic [NCH-1:0]    stb,
   output logic              frame_tick,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam logic [NCH-1:0] FRAME_MASK = NCH'(1) << FRAME_CH;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [FCNT_W-1:0]   frame_cnt_q;
   logic [NCH-1:0]      rise;
   logic                prime;
   logic                frame_evt;

   assign prime     = (state == ST_PRIME);
   assign frame_evt = |(rise & FRAME_MASK);
   assign frame_cnt = frame_cnt_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      edge_strobe u_edge (
         .clk      (clk),
         .rst_n    (rst_n),
         .en_prime (prime),
         .bit_in   (sel_bit(clk_div, SEL[SEL_W*i +: SEL_W])),
         .stb      (stb[i]),
         .rise     (rise[i])
      );
   end

   // A frame event arriving in the same cycle pause rises is still handled in
   // RUN; the hold takes effect from the next cycle. cnt only moves on events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_PRIME;
         cnt         <= '0;
         frame_cnt_q <= '0;
         frame_tick  <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         case (state)
            ST_PRIME: state <= pause ? ST_HOLD : ST_RUN;
            ST_RUN: begin
               if (pause)
                  state <= ST_HOLD;
               if (frame_evt && (period != '0)) begin
                  if (cnt == '0) begin
                     frame_tick  <= 1'b1;
                     cnt         <= period - CNT_W'(1);
                     frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (!pause)
                  state <= ST_RUN;
            end
            default: state <= ST_PRIME;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: directed segment table plus randomized stimulus,
// both checked cycle by cycle against a rule-level reference model.
module tb_clk_tick_gen;

   localparam int          NCH = 4;
   localparam logic [19:0] SEL = {5'd24, 5'd20, 5'd16, 5'd2};
   localparam int          FCH = 0;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [31:0]     clk_div = 32'h0000_0004;
   logic [7:0]      period = 8'd3;
   logic            pause = 1'b0;
   logic [NCH-1:0]  stb;
   logic            frame_tick;
   logic [15:0]     frame_cnt;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   bit              primed;
   bit              run_mode;
   logic [31:0]     prev_div;
   int              left;
   logic [15:0]     m_fcnt;
   logic [NCH-1:0]  m_stb;
   logic            m_tick;
   int              seg_stb, seg_tick;

   typedef struct {
      int          ncyc;
      logic [7:0]  period;
      logic        pause;
      int          exp_stb;
      int          exp_tick;
      logic [15:0] exp_fcnt;
   } seg_t;
   seg_t tbl[11];

   clk_tick_gen #(.NCH(NCH), .SEL(SEL), .FRAME_CH(FCH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_div    (clk_div),
      .period     (period),
      .pause      (pause),
      .stb        (stb),
      .frame_tick (frame_tick),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic selbit(input logic [31:0] v, input int ch);
      logic [4:0] idx;
      idx = SEL[5*ch +: 5];
      return v[idx];
   endfunction

   task automatic model_reset();
      primed = 0; run_mode = 0; left = 0;
      m_fcnt = '0; m_stb = '0; m_tick = 1'b0; prev_div = '0;
   endtask

   // Frame rule: tick on the event that finds no events owed, then owe period-1.
   task automatic model_step();
      logic [NCH-1:0] s;
      s = '0;
      m_tick = 1'b0;
      if (!primed) begin
         primed = 1;
      end else begin
         for (int ch = 0; ch < NCH; ch++)
            s[ch] = selbit(clk_div, ch) && !selbit(prev_div, ch);
         if (run_mode && s[FCH] && period != 0) begin
            if (left == 0) begin
               m_tick = 1'b1;
               left   = int'(period) - 1;
               m_fcnt = m_fcnt + 16'd1;
            end else begin
               left = left - 1;
            end
         end
      end
      m_stb    = s;
      run_mode = !pause;
      prev_div = clk_div;
   endtask

   task automatic check(input string nm);
      vectors++;
      if (stb !== m_stb || frame_tick !== m_tick || frame_cnt !== m_fcnt) begin
         miscompares++;
         $display("FAIL %s: got stb=%b tick=%b cnt=%h, want stb=%b tick=%b cnt=%h",
                  nm, stb, frame_tick, frame_cnt, m_stb, m_tick, m_fcnt);
      end
   endtask

   task automatic cycle(input bit cnt_en, input string nm);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check(nm);
      seg_stb  += int'(stb[0]);
      seg_tick += int'(frame_tick);
      if (cnt_en) clk_div = clk_div + 32'd1;
   endtask

   task automatic cmp_int(input string nm, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   initial begin
      tbl[0]  = '{8,  8'd3, 1'b0, 0, 0, 16'd0};  // priming: bit 2 already high
      tbl[1]  = '{24, 8'd3, 1'b0, 3, 1, 16'd1};
      tbl[2]  = '{48, 8'd3, 1'b0, 6, 2, 16'd3};
      tbl[3]  = '{9,  8'd3, 1'b0, 2, 1, 16'd4};  // leaves one event owed
      tbl[4]  = '{20, 8'd3, 1'b1, 2, 0, 16'd4};  // pause
      tbl[5]  = '{12, 8'd3, 1'b0, 2, 1, 16'd5};  // tick on 2nd strobe after release
      tbl[6]  = '{24, 8'd5, 1'b0, 3, 1, 16'd6};  // new period waits for reload
      tbl[7]  = '{40, 8'd5, 1'b0, 5, 1, 16'd7};
      tbl[8]  = '{40, 8'd0, 1'b0, 5, 0, 16'd7};  // period 0 freezes
      tbl[9]  = '{32, 8'd5, 1'b0, 4, 0, 16'd7};
      tbl[10] = '{8,  8'd5, 1'b0, 1, 1, 16'd8};

      model_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (stb !== '0 || frame_tick !== 1'b0 || frame_cnt !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_state: got stb=%b tick=%b cnt=%h, want all zero",
                  stb, frame_tick, frame_cnt);
      end
      rst_n = 1'b1;

      for (int s = 0; s < 11; s++) begin
         period = tbl[s].period;
         pause  = tbl[s].pause;
         seg_stb = 0; seg_tick = 0;
         for (int c = 0; c < tbl[s].ncyc; c++) cycle(1'b1, $sformatf("seg%0d", s));
         cmp_int($sformatf("seg%0d_strobes", s), seg_stb, tbl[s].exp_stb);
         cmp_int($sformatf("seg%0d_ticks", s), seg_tick, tbl[s].exp_tick);
         cmp_int($sformatf("seg%0d_frame_cnt", s), int'(frame_cnt), int'(tbl[s].exp_fcnt));
      end

      // frame counter wrap from a preloaded 16'hFFFF
      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      m_fcnt = 16'hFFFF;
      seg_stb = 0; seg_tick = 0;
      for (int c = 0; c < 40; c++) cycle(1'b1, "wrap");
      cmp_int("wrap_ticks", seg_tick, 1);
      cmp_int("wrap_frame_cnt", int'(frame_cnt), 0);
      cmp_int("wrap_tick_high", int'(frame_tick), 1);

      // asynchronous clear mid-cycle, no clock edge in between
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (stb !== '0 || frame_tick !== 1'b0 || frame_cnt !== 16'h0) begin
         miscompares++;
         $display("FAIL async_reset: got stb=%b tick=%b cnt=%h, want all zero",
                  stb, frame_tick, frame_cnt);
      end
      model_reset();
      @(negedge clk);
      clk_div = 32'h0000_0004;
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) cycle(1'b1, "reprime");

      // randomized stimulus, including occasional mid-run resets
      for (int n = 0; n < 2000; n++) begin
         int r;
         cycle(1'b0, "random");
         r = $urandom_range(0, 99);
         if (r < 70)      clk_div = clk_div + 32'd1;
         else if (r < 90) clk_div = clk_div + (32'd1 << $urandom_range(0, 26));
         else if (r < 97) clk_div = $urandom;
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         if ($urandom_range(0, 63) == 0) period = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            model_reset();
            repeat (2) begin
               @(negedge clk);
               check("in_reset");
               clk_div = $urandom;
            end
            rst_n = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
